// File: rtl/obi_mem_responder_if.sv
// OBI address-phase / response-phase bus between a core-side initiator and a memory target.
// There is no rready: the initiator must take every response in the cycle it is presented.
interface obi_mem_responder_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/obi_mem_responder.sv
// OBI memory target for core testbenches: byte-enabled RAM behind a fixed-latency,
// strictly in-order response pipeline with a bounded number of transactions in flight.
module obi_mem_responder #(
    parameter int unsigned ADDR_WIDTH      = 20,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    obi_mem_responder_if.slave bus,
    input  logic               gnt_stall_i,
    output logic [CNT_W-1:0]   outstanding_o
);

    localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH   = 1 << WORD_AW;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } stage_t;

    logic [31:0]        mem [DEPTH];
    logic [WORD_AW-1:0] word_idx;
    logic               in_range;
    logic               gnt;
    logic               accept;
    logic               resp_valid;
    stage_t             stage_in;
    stage_t             pipe_q [RESP_LATENCY];
    logic [CNT_W-1:0]   outstanding_q;
    logic [CNT_W-1:0]   outstanding_d;
    logic               unused_addr_lsb;

    assign unused_addr_lsb = ^bus.addr[1:0];

    assign word_idx = bus.addr[ADDR_WIDTH-1:2];
    assign in_range = (bus.addr[31:ADDR_WIDTH] == '0);

    // Grant looks only at the registered count, so a full pipe blocks grant even
    // in the cycle a response retires; this keeps rvalid off the gnt path.
    assign gnt    = bus.req & ~gnt_stall_i & (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    assign accept = bus.req & gnt;

    assign bus.gnt = gnt;

    always_comb begin
        stage_in       = '0;
        stage_in.valid = accept;
        stage_in.err   = accept & ~in_range;
        if (accept && !bus.we && in_range) begin
            stage_in.rdata = mem[word_idx];
        end
    end

    // RAM has no reset so accepted writes survive a mid-run reset pulse.
    always_ff @(posedge clk_i) begin
        if (accept && bus.we && in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (bus.be[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RESP_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage_in;
            for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign resp_valid = pipe_q[RESP_LATENCY-1].valid;
    assign bus.rvalid = resp_valid;
    assign bus.rdata  = pipe_q[RESP_LATENCY-1].rdata;
    assign bus.err    = pipe_q[RESP_LATENCY-1].err;

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({accept, resp_valid})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign outstanding_o = outstanding_q;

    a_no_orphan_rvalid: assert property (
        @(posedge clk_i) disable iff (!rst_ni) resp_valid |-> (outstanding_q != '0)
    );

    a_count_bounded: assert property (
        @(posedge clk_i) disable iff (!rst_ni) outstanding_q <= CNT_W'(MAX_OUTSTANDING)
    );

endmodule
